fpq_link_scheduler: RTL and testbench
=====================================

# fpq_link_scheduler

Time-aware link scheduler sharing one serial output link between one time-triggered (TT) queue and two rate-constrained (RC) queues. A TT window repeats every `CYCLE_LEN` bit times. TT has exclusive use of the link inside the window, and RC packets are admitted outside it only if they finish before the next window opens (guard band). It sits between the per-queue packet sources and the TT/RC mux and state LEDs, and drives the grant and state signals they consume.

## Interface
- `CYCLE_LEN`, 200: schedule cycle length in bit ticks (2..255).
- `TT_OFFSET`, 0: first bit tick of the TT window within the cycle (< `CYCLE_LEN`).
- `TT_WIN`, 64: TT window length in bit ticks (1..`CYCLE_LEN`-1); the window must not wrap past the cycle end.
- `clk_10MHz` input 1: system clock; all state updates on its rising edge.
- `rst` input 1: reset; asynchronous, active-high.
- `bit_tick` input 1: one-cycle pulse per link bit time.
- `req_tt` input 1: TT queue has a packet; held until `tx_done` for its grant.
- `req_rc` input 2: RC queue requests; bit 0 is RC0, bit 1 is RC1; same hold rule.
- `pkt_len_tt` input 8: TT head-packet length in bits; 0 is treated as 1.
- `pkt_len_rc` input 16: RC0 length in [7:0], RC1 length in [15:8]; 0 is treated as 1.
- `grant_tt` output 1: TT owns the link; held for the whole packet.
- `grant_rc` output 2: one-hot RC ownership; held for the whole packet.
- `tx_done` output 1: one-cycle pulse on the last bit tick of a granted packet.
- `cur_state` output 2: 00 IDLE, 01 TT_TX, 10 RC_TX, 11 BLOCKED.
- `tt_window` output 1: current cycle position is inside the TT window.
- `err_tt_oversize` output 1: one-cycle pulse when a TT packet cannot fit in the remaining window.
- `cyc_pos` output 8: current cycle position, for display.

## Operation
- `cyc_pos` increments on every `bit_tick` and wraps from `CYCLE_LEN`-1 to 0. It runs independently of grants.
- `tt_window` = (`TT_OFFSET` ≤ `cyc_pos` < `TT_OFFSET`+`TT_WIN`), evaluated combinationally from the registered `cyc_pos`.
- `win_left` = `TT_OFFSET`+`TT_WIN`-`cyc_pos` (valid only inside the window).
- `gap` = (`TT_OFFSET`-`cyc_pos`) mod `CYCLE_LEN`, computed in 9 bits (valid only outside the window).
- The arbitration decision is made in IDLE or BLOCKED on every clk cycle (not gated by `bit_tick`). "len" is the effective length: the input length, or 1 if the input is 0.
  - Inside the window, if `req_tt` is set and len_tt ≤ `win_left`: go to TT_TX and load the down-counter with len_tt.
  - Inside the window, if `req_tt` is set and len_tt > `win_left`: pulse `err_tt_oversize` once per window (a per-window flag suppresses repeats) and stay BLOCKED.
  - Inside the window otherwise: BLOCKED. RC is never granted inside the window.
  - Outside the window: RC candidates are requesters with len ≤ `gap`. If both qualify, round-robin starting after the last-served RC; the pointer resets to RC1 so RC0 wins first. Grant the winner, enter RC_TX, load its len. If requests exist but none fit: BLOCKED. If there are no requests: IDLE.
- In TT_TX or RC_TX the down-counter decrements on `bit_tick`. On the `bit_tick` where the counter equals 1, pulse `tx_done` and return to IDLE/BLOCKED decision on the next cycle. Grants drop in the same cycle as the `tx_done` pulse.
- Lengths are sampled only at grant. Changes to `pkt_len_*` during transmission are ignored.
- A request dropped mid-packet does not abort the packet; the transmission runs to completion.
- The per-window error flag clears when `tt_window` falls.

## Timing
- Reset values: `cyc_pos`=0, counter=0, state IDLE, all grants 0, `tx_done`=0, `err_tt_oversize`=0, RR pointer=RC1. `tt_window` follows from `cyc_pos`=0.
- Grant latency: request sampled at clk edge N, grant visible after edge N (registered). The first data bit is the next `bit_tick` after the grant.
- Packet duration is exactly len `bit_tick`s.
- A new grant is possible one clk after `tx_done`, with a 0-tick gap provided no `bit_tick` falls in that cycle.
- Simultaneous `bit_tick` and decision: the decision uses the pre-increment `cyc_pos`, and the counter load counts from the following tick.
- An RC packet with len = `gap` ends exactly on the last tick before the window opens, so TT can be granted at window start.
- Asserting `rst` mid-packet clears all grants immediately (asynchronously). No `tx_done` is issued for the aborted packet.

## Structure
- A shared `fpq_pkg` holds the state encoding (IDLE/TT_TX/RC_TX/BLOCKED), the queue index constants, and the 8-bit length width.
- Sub-module `fpq_cycle_timer` contains `cyc_pos`, `tt_window`, `win_left` and `gap`. The FSM, round-robin and down-counter live in the top level.

## Test plan
- Window 0..63, cycle 200, `req_tt` with len 10 at `cyc_pos`=0 → `grant_tt` for 10 ticks, `tx_done` on tick 10, `cur_state` 01 then back to 11 or 00.
- `req_rc`=11, lengths 20/20, `cyc_pos`=64 → RC0 granted 64..83, then RC1 84..103, then RC0 again (round-robin alternation).
- RC0 len 50 at `cyc_pos`=160 (`gap`=40) → no grant, state 11. At cycle wrap TT proceeds; RC0 is granted at `cyc_pos`=64.
- RC0 len exactly 40 at `cyc_pos`=160 → granted; `tx_done` at `cyc_pos` 199→0 tick; TT granted at 0.
- TT len 70 at window start → one `err_tt_oversize` pulse, no grant for that window, no RC grant inside the window.
- `rst` asserted mid-RC packet → grants 0 asynchronously, `cyc_pos`=0, no `tx_done`; normal operation resumes after release.

Source files
------------

// File: rtl/fpq_pkg.sv
// Shared definitions for the TT/RC link scheduler: state encoding, queue indices, length width.
package fpq_pkg;

   localparam int LEN_W = 8;

   // Queue indices: RC0/RC1 are bit positions in req_rc/grant_rc.
   localparam int Q_RC0 = 0;
   localparam int Q_RC1 = 1;
   localparam int Q_TT  = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_TT_TX   = 2'b01,
      ST_RC_TX   = 2'b10,
      ST_BLOCKED = 2'b11
   } state_t;

   // A zero length still occupies one bit time on the link.
   function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
      logic [LEN_W-1:0] r;
      r = len;
      if (len == '0) r = {{(LEN_W-1){1'b0}}, 1'b1};
      return r;
   endfunction

endpackage

// File: rtl/fpq_cycle_timer.sv
// Schedule-cycle position counter plus window and guard-band distances derived from it.
module fpq_cycle_timer
   import fpq_pkg::*;
#(
   parameter int CYCLE_LEN = 200,
   parameter int TT_OFFSET = 0,
   parameter int TT_WIN    = 64
) (
   input  logic             clk_10MHz,
   input  logic             rst,
   input  logic             bit_tick,
   output logic [LEN_W-1:0] cyc_pos,
   output logic             tt_window,
   output logic [8:0]       win_left,
   output logic [8:0]       gap
);

   localparam logic [8:0]       WIN_LO  = 9'(TT_OFFSET);
   localparam logic [8:0]       WIN_HI  = 9'(TT_OFFSET + TT_WIN);
   localparam logic [8:0]       WIN_LEN = 9'(TT_WIN);
   localparam logic [8:0]       CYC     = 9'(CYCLE_LEN);
   localparam logic [LEN_W-1:0] LAST    = LEN_W'(CYCLE_LEN - 1);

   logic [8:0] pos9;
   logic [8:0] rel;

   assign pos9 = {1'b0, cyc_pos};
   // Positions before the window wrap to >= 257 in 9 bits, so one compare covers both edges.
   assign rel       = pos9 - WIN_LO;
   assign tt_window = (rel < WIN_LEN);
   assign win_left  = WIN_HI - pos9;
   assign gap       = (pos9 > WIN_LO) ? (WIN_LO + CYC - pos9) : (WIN_LO - pos9);

   // Free-running position, advancing once per link bit time.
   always_ff @(posedge clk_10MHz or posedge rst) begin
      if (rst)           cyc_pos <= '0;
      else if (bit_tick) cyc_pos <= (cyc_pos == LAST) ? '0 : cyc_pos + 1'b1;
   end

endmodule

// File: rtl/fpq_link_scheduler.sv
// Time-aware scheduler: TT owns the link inside its window, RC queues share the rest
// round-robin, and only if the packet ends before the next window opens.
module fpq_link_scheduler
   import fpq_pkg::*;
#(
   parameter int CYCLE_LEN = 200,
   parameter int TT_OFFSET = 0,
   parameter int TT_WIN    = 64
) (
   input  logic        clk_10MHz,
   input  logic        rst,
   input  logic        bit_tick,
   input  logic        req_tt,
   input  logic [1:0]  req_rc,
   input  logic [7:0]  pkt_len_tt,
   input  logic [15:0] pkt_len_rc,
   output logic        grant_tt,
   output logic [1:0]  grant_rc,
   output logic        tx_done,
   output logic [1:0]  cur_state,
   output logic        tt_window,
   output logic        err_tt_oversize,
   output logic [7:0]  cyc_pos
);

   logic [8:0]       win_left;
   logic [8:0]       gap;
   state_t           state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             rr_q, rr_d;          // index of the last-served RC queue
   logic             err_flag_q, err_flag_d;
   logic             grant_tt_d, tx_done_d, err_d;
   logic [1:0]       grant_rc_d;
   logic [LEN_W-1:0] len_tt, len_rc0, len_rc1;
   logic             fit_tt, fit0, fit1, pick;

   fpq_cycle_timer #(
      .CYCLE_LEN(CYCLE_LEN),
      .TT_OFFSET(TT_OFFSET),
      .TT_WIN   (TT_WIN)
   ) u_timer (
      .clk_10MHz(clk_10MHz),
      .rst      (rst),
      .bit_tick (bit_tick),
      .cyc_pos  (cyc_pos),
      .tt_window(tt_window),
      .win_left (win_left),
      .gap      (gap)
   );

   assign len_tt  = eff_len(pkt_len_tt);
   assign len_rc0 = eff_len(pkt_len_rc[7:0]);
   assign len_rc1 = eff_len(pkt_len_rc[15:8]);
   assign fit_tt  = ({1'b0, len_tt} <= win_left);
   assign fit0    = req_rc[Q_RC0] && ({1'b0, len_rc0} <= gap);
   assign fit1    = req_rc[Q_RC1] && ({1'b0, len_rc1} <= gap);
   // With both eligible, serve the one not served last; otherwise the sole eligible one.
   assign pick    = (fit0 && fit1) ? ~rr_q : fit1;

   assign cur_state = state_q;

   // Arbitration while the link is free, bit counting while it is owned.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rr_d       = rr_q;
      err_flag_d = err_flag_q;
      grant_tt_d = grant_tt;
      grant_rc_d = grant_rc;
      tx_done_d  = 1'b0;
      err_d      = 1'b0;
      case (state_q)
         ST_TT_TX, ST_RC_TX: begin
            if (bit_tick) begin
               if (cnt_q == LEN_W'(1)) begin
                  state_d    = ST_IDLE;
                  cnt_d      = '0;
                  grant_tt_d = 1'b0;
                  grant_rc_d = 2'b00;
                  tx_done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         default: begin
            grant_tt_d = 1'b0;
            grant_rc_d = 2'b00;
            if (tt_window) begin
               state_d = ST_BLOCKED;
               if (req_tt && fit_tt) begin
                  state_d    = ST_TT_TX;
                  cnt_d      = len_tt;
                  grant_tt_d = 1'b1;
               end else if (req_tt && !err_flag_q) begin
                  err_d      = 1'b1;
                  err_flag_d = 1'b1;
               end
            end else if (fit0 || fit1) begin
               state_d    = ST_RC_TX;
               cnt_d      = pick ? len_rc1 : len_rc0;
               grant_rc_d = pick ? 2'b10 : 2'b01;
               rr_d       = pick;
            end else if (req_rc != 2'b00) begin
               state_d = ST_BLOCKED;
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase
      // Oversize reporting re-arms once the window closes.
      if (!tt_window) err_flag_d = 1'b0;
   end

   // State, counter and registered outputs; reset drops grants immediately.
   always_ff @(posedge clk_10MHz or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         cnt_q           <= '0;
         rr_q            <= 1'b1;
         err_flag_q      <= 1'b0;
         grant_tt        <= 1'b0;
         grant_rc        <= 2'b00;
         tx_done         <= 1'b0;
         err_tt_oversize <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         rr_q            <= rr_d;
         err_flag_q      <= err_flag_d;
         grant_tt        <= grant_tt_d;
         grant_rc        <= grant_rc_d;
         tx_done         <= tx_done_d;
         err_tt_oversize <= err_d;
      end
   end

endmodule

// File: tb/tb_fpq_link_scheduler.sv
// Self-checking bench for fpq_link_scheduler: decision vectors, directed sequences, random run.
module tb_fpq_link_scheduler;

   localparam int CL  = 200;
   localparam int OFF = 0;
   localparam int WIN = 64;
   localparam int NV  = 20;

   logic        clk_10MHz = 1'b0;
   logic        rst = 1'b1;
   logic        bit_tick = 1'b0;
   logic        req_tt = 1'b0;
   logic [1:0]  req_rc = 2'b00;
   logic [7:0]  pkt_len_tt = 8'd0;
   logic [15:0] pkt_len_rc = 16'd0;
   logic        grant_tt;
   logic [1:0]  grant_rc;
   logic        tx_done;
   logic [1:0]  cur_state;
   logic        tt_window;
   logic        err_tt_oversize;
   logic [7:0]  cyc_pos;

   int checks = 0;
   int errors = 0;

   always #50 clk_10MHz = ~clk_10MHz;

   fpq_link_scheduler #(.CYCLE_LEN(CL), .TT_OFFSET(OFF), .TT_WIN(WIN)) dut (
      .clk_10MHz      (clk_10MHz),
      .rst            (rst),
      .bit_tick       (bit_tick),
      .req_tt         (req_tt),
      .req_rc         (req_rc),
      .pkt_len_tt     (pkt_len_tt),
      .pkt_len_rc     (pkt_len_rc),
      .grant_tt       (grant_tt),
      .grant_rc       (grant_rc),
      .tx_done        (tx_done),
      .cur_state      (cur_state),
      .tt_window      (tt_window),
      .err_tt_oversize(err_tt_oversize),
      .cyc_pos        (cyc_pos)
   );

   // ---------------- reference model (link owner + ticks remaining) ----------------
   int m_pos, m_owner, m_left, m_last_rc;   // owner: -1 free, 0 RC0, 1 RC1, 2 TT
   bit m_blocked, m_errflag, m_done, m_err;

   function automatic int elen(input int l);
      return (l == 0) ? 1 : l;
   endfunction

   task automatic model_reset();
      m_pos = 0; m_owner = -1; m_left = 0; m_last_rc = 1;
      m_blocked = 0; m_errflag = 0; m_done = 0; m_err = 0;
   endtask

   task automatic model_step(input bit t);
      bit in_win, ok0, ok1;
      int g, l0, l1, pk;
      in_win = (m_pos >= OFF) && (m_pos < OFF + WIN);
      m_done = 0;
      m_err  = 0;
      if (m_owner >= 0) begin
         if (t) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_done = 1; m_owner = -1; m_blocked = 0;
            end
         end
      end else if (in_win) begin
         m_blocked = 1;
         if (req_tt && elen(int'(pkt_len_tt)) <= OFF + WIN - m_pos) begin
            m_owner = 2; m_left = elen(int'(pkt_len_tt)); m_blocked = 0;
         end else if (req_tt && !m_errflag) begin
            m_err = 1; m_errflag = 1;
         end
      end else begin
         g   = ((OFF - m_pos) % CL + CL) % CL;
         l0  = elen(int'(pkt_len_rc[7:0]));
         l1  = elen(int'(pkt_len_rc[15:8]));
         ok0 = req_rc[0] && (l0 <= g);
         ok1 = req_rc[1] && (l1 <= g);
         pk  = -1;
         if (ok0 && ok1) pk = (m_last_rc == 0) ? 1 : 0;
         else if (ok0)   pk = 0;
         else if (ok1)   pk = 1;
         m_blocked = 0;
         if (pk >= 0) begin
            m_owner = pk; m_left = (pk == 0) ? l0 : l1; m_last_rc = pk;
         end else if (req_rc != 2'b00) begin
            m_blocked = 1;
         end
      end
      if (!in_win) m_errflag = 0;
      if (t) m_pos = (m_pos + 1) % CL;
   endtask

   function automatic logic [15:0] exp_vec();
      logic [1:0] st, grc;
      logic       w;
      st  = (m_owner == 2) ? 2'd1 : (m_owner >= 0) ? 2'd2 : m_blocked ? 2'd3 : 2'd0;
      grc = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
      w   = (m_pos >= OFF) && (m_pos < OFF + WIN);
      return {(m_owner == 2), grc, m_done, st, w, m_err, 8'(m_pos)};
   endfunction

   function automatic logic [15:0] dut_vec();
      return {grant_tt, grant_rc, tx_done, cur_state, tt_window, err_tt_oversize, cyc_pos};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h (cyc_pos %0d)", name, got, exp, cyc_pos);
      end
   endtask

   // One clk with the current inputs; model advances on the same edge.
   task automatic step(input bit t);
      bit_tick = t;
      @(posedge clk_10MHz);
      model_step(t);
      @(negedge clk_10MHz);
      check("model", 32'(dut_vec()), 32'(exp_vec()));
   endtask

   task automatic do_reset();
      rst = 1'b1; bit_tick = 1'b0; req_tt = 1'b0; req_rc = 2'b00;
      pkt_len_tt = 8'd0; pkt_len_rc = 16'd0;
      @(negedge clk_10MHz);
      @(negedge clk_10MHz);
      rst = 1'b0;
      model_reset();
   endtask

   // ---------------- single-decision vectors ----------------
   typedef struct {
      int         pos;
      bit         rtt;
      bit [1:0]   rrc;
      int         ltt, l0, l1;
      bit [1:0]   st;
      bit         gtt;
      bit [1:0]   grc;
      bit         err;
   } vec_t;
   vec_t vt[NV];

   initial begin
      #(100 * 30000);
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] got_g[3];
      int         got_p[3];
      int         k, n, e;
      bit         ph;
      logic [1:0] prev;

      //          pos rtt rrc   ltt l0  l1   st    gtt grc   err
      vt[0]  = '{0,   1, 2'b00, 10, 0,  0,  2'b01, 1, 2'b00, 0};
      vt[1]  = '{0,   1, 2'b00, 64, 0,  0,  2'b01, 1, 2'b00, 0};
      vt[2]  = '{0,   1, 2'b00, 65, 0,  0,  2'b11, 0, 2'b00, 1};
      vt[3]  = '{10,  1, 2'b00, 54, 0,  0,  2'b01, 1, 2'b00, 0};
      vt[4]  = '{10,  1, 2'b00, 55, 0,  0,  2'b11, 0, 2'b00, 1};
      vt[5]  = '{0,   1, 2'b00, 0,  0,  0,  2'b01, 1, 2'b00, 0};
      vt[6]  = '{5,   0, 2'b01, 0,  1,  0,  2'b11, 0, 2'b00, 0};
      vt[7]  = '{5,   0, 2'b00, 0,  0,  0,  2'b11, 0, 2'b00, 0};
      vt[8]  = '{64,  0, 2'b00, 0,  0,  0,  2'b00, 0, 2'b00, 0};
      vt[9]  = '{64,  0, 2'b11, 0,  20, 20, 2'b10, 0, 2'b01, 0};
      vt[10] = '{160, 0, 2'b01, 0,  50, 0,  2'b11, 0, 2'b00, 0};
      vt[11] = '{160, 0, 2'b01, 0,  40, 0,  2'b10, 0, 2'b01, 0};
      vt[12] = '{160, 0, 2'b11, 0,  41, 40, 2'b10, 0, 2'b10, 0};
      vt[13] = '{199, 0, 2'b01, 0,  1,  0,  2'b10, 0, 2'b01, 0};
      vt[14] = '{199, 0, 2'b01, 0,  2,  0,  2'b11, 0, 2'b00, 0};
      vt[15] = '{100, 0, 2'b10, 0,  0,  0,  2'b10, 0, 2'b10, 0};
      vt[16] = '{63,  1, 2'b00, 1,  0,  0,  2'b01, 1, 2'b00, 0};
      vt[17] = '{63,  1, 2'b00, 2,  0,  0,  2'b11, 0, 2'b00, 1};
      vt[18] = '{64,  1, 2'b00, 5,  0,  0,  2'b00, 0, 2'b00, 0};
      vt[19] = '{70,  1, 2'b11, 5,  200, 0, 2'b10, 0, 2'b10, 0};

      // reset state: IDLE, no grants, position 0 which lies inside the window
      do_reset();
      check("reset", 32'(dut_vec()), 32'({1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 8'd0}));

      for (int v = 0; v < NV; v++) begin
         do_reset();
         repeat (vt[v].pos) step(1'b1);
         req_tt     = vt[v].rtt;
         req_rc     = vt[v].rrc;
         pkt_len_tt = 8'(vt[v].ltt);
         pkt_len_rc = {8'(vt[v].l1), 8'(vt[v].l0)};
         step(1'b0);
         check($sformatf("vec%0d", v), 32'({cur_state, grant_tt, grant_rc, err_tt_oversize}),
               32'({vt[v].st, vt[v].gtt, vt[v].grc, vt[v].err}));
      end

      // A: TT len 10 at window start lasts exactly 10 ticks
      do_reset();
      req_tt = 1'b1; pkt_len_tt = 8'd10;
      step(1'b0);
      check("A_grant", 32'(grant_tt), 32'd1);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b1);
         if (i == 9) check("A_done", 32'({tx_done, grant_tt, cyc_pos}), 32'({1'b1, 1'b0, 8'd10}));
         else if (grant_tt && !tx_done) n++;
      end
      check("A_held", 32'(n), 32'd9);
      req_tt = 1'b0;
      step(1'b0);
      check("A_after", 32'(cur_state), 32'd3);

      // B: RC round-robin, 20-bit packets back to back from position 64
      do_reset();
      repeat (64) step(1'b1);
      req_rc = 2'b11; pkt_len_rc = {8'd20, 8'd20};
      ph = 1'b0; prev = 2'b00; k = 0;
      for (int i = 0; i < 3; i++) begin got_g[i] = 2'b00; got_p[i] = -1; end
      for (int i = 0; i < 200 && k < 3; i++) begin
         step(ph);
         ph = ~ph;
         if (grant_rc != 2'b00 && prev == 2'b00) begin
            got_g[k] = grant_rc; got_p[k] = int'(cyc_pos); k++;
         end
         prev = grant_rc;
      end
      req_rc = 2'b00;
      check("B_count", 32'(k), 32'd3);
      check("B_g0", 32'({got_g[0], 8'(got_p[0])}), 32'({2'b01, 8'd64}));
      check("B_g1", 32'({got_g[1], 8'(got_p[1])}), 32'({2'b10, 8'd84}));
      check("B_g2", 32'({got_g[2], 8'(got_p[2])}), 32'({2'b01, 8'd104}));

      // C: RC0 len 50 at 160 does not fit the guard band; first grant after the window
      do_reset();
      repeat (160) step(1'b1);
      req_rc = 2'b01; pkt_len_rc = 16'd50;
      step(1'b1);
      check("C_blocked", 32'({cur_state, grant_rc}), 32'({2'b11, 2'b00}));
      n = -1;
      for (int i = 0; i < 200 && n < 0; i++) begin
         step(1'b1);
         if (grant_rc != 2'b00) n = int'(cyc_pos);
      end
      // decision at 64 with a coincident tick, so position reads 65 when the grant shows
      check("C_first_pos", 32'(n), 32'd65);
      req_rc = 2'b00;

      // D: RC0 len exactly equal to gap ends on the wrap tick; TT follows at 0
      do_reset();
      repeat (160) step(1'b1);
      req_rc = 2'b01; pkt_len_rc = 16'd40;
      step(1'b0);
      check("D_grant", 32'(grant_rc), 32'd1);
      for (int i = 0; i < 40; i++) begin
         step(1'b1);
         if (i == 39) check("D_done", 32'({tx_done, grant_rc, cyc_pos}), 32'({1'b1, 2'b00, 8'd0}));
      end
      req_rc = 2'b00; req_tt = 1'b1; pkt_len_tt = 8'd10;
      step(1'b0);
      check("D_tt", 32'({grant_tt, cur_state, cyc_pos}), 32'({1'b1, 2'b01, 8'd0}));
      req_tt = 1'b0;

      // E: oversize TT: one error per window, never any grant
      do_reset();
      req_tt = 1'b1; pkt_len_tt = 8'd70;
      e = 0; n = 0;
      for (int i = 0; i < 210; i++) begin
         step(1'b1);
         if (err_tt_oversize) e++;
         if (grant_tt || grant_rc != 2'b00) n++;
      end
      req_tt = 1'b0;
      check("E_errs", 32'(e), 32'd2);
      check("E_grants", 32'(n), 32'd0);

      // F: reset mid RC packet clears grants without a clock
      do_reset();
      repeat (64) step(1'b1);
      req_rc = 2'b01; pkt_len_rc = 16'd20;
      step(1'b0);
      repeat (5) step(1'b1);
      #10 rst = 1'b1;
      #1;
      check("F_async", 32'({grant_tt, grant_rc, tx_done, cur_state, cyc_pos}), 32'd0);
      @(negedge clk_10MHz);
      check("F_nodone", 32'(tx_done), 32'd0);
      rst = 1'b0; req_rc = 2'b00;
      model_reset();
      req_tt = 1'b1; pkt_len_tt = 8'd5;
      step(1'b0);
      check("F_resume", 32'({grant_tt, cur_state}), 32'({1'b1, 2'b01}));
      req_tt = 1'b0;

      // Random traffic against the model
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 7) == 0) req_tt = ~req_tt;
         if ($urandom_range(0, 7) == 0) req_rc[0] = ~req_rc[0];
         if ($urandom_range(0, 7) == 0) req_rc[1] = ~req_rc[1];
         if ($urandom_range(0, 15) == 0) pkt_len_tt = 8'($urandom_range(0, 70));
         if ($urandom_range(0, 15) == 0) pkt_len_rc[7:0] = 8'($urandom_range(0, 60));
         if ($urandom_range(0, 15) == 0) pkt_len_rc[15:8] = 8'($urandom_range(0, 60));
         step(1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
